// File: rtl/seq_adder16_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: controller state encoding
// and the width of the time-shared adder slice.
package seq_adder16_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_adder16_ctrl_add4.sv
// Combinational 4-bit ripple adder slice. c3 is the carry into bit 3, used
// by the controller to form two's-complement overflow on the top nibble.
module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[4];
    assign c3 = c[3];

endmodule

// File: rtl/seq_adder16_ctrl.sv
// Sequential W-bit adder: one add4 slice applied to one nibble per clock,
// LSB first, with registered sum/cout/ovf and a one-cycle done pulse.
module seq_adder16_ctrl
    import seq_adder16_ctrl_pkg::*;
#(
    parameter int N_NIB = 4,
    localparam int W    = NIB_W * N_NIB
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int IW                = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_NIB - 1);

    state_t         state, state_nxt;
    logic [W-1:0]   a_q, b_q, sum_q;
    logic           cin_q, carry_q, cout_q, ovf_q;
    logic [IW-1:0]  idx_q;

    logic [NIB_W-1:0] nib_a, nib_b, nib_s;
    logic             nib_ci, nib_co, nib_c3;

    assign nib_a  = a_q[idx_q * NIB_W +: NIB_W];
    assign nib_b  = b_q[idx_q * NIB_W +: NIB_W];
    // Nibble 0 takes the latched cin so no carry survives from a previous operation.
    assign nib_ci = (idx_q == '0) ? cin_q : carry_q;

    add4 u_add4 (
        .a  (nib_a),
        .b  (nib_b),
        .ci (nib_ci),
        .s  (nib_s),
        .co (nib_co),
        .c3 (nib_c3)
    );

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (idx_q == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        cin_q <= cin;
                        idx_q <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx_q * NIB_W +: NIB_W] <= nib_s;
                    carry_q                       <= nib_co;
                    if (idx_q == LAST_IDX) begin
                        cout_q <= nib_co;
                        ovf_q  <= nib_co ^ nib_c3;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
